// File: rtl/adc_sar_redundant_recon.sv
// Reconstructs SAR codes from redundant weighted comparator decisions and averages 2**avg_sel conversions.
// Latency: dout_valid rises in the 2nd cycle after the edge that samples the last decision of the group.
// Backpressure: none; decisions are taken only on cmp_valid in CONV, abort cancels the group at any time.
module adc_sar_redundant_recon #(
    parameter int N            = 8,
    parameter int M            = 10,
    parameter int AVG_MAX_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_valid,
    input  logic             cmp,
    input  logic [M*N-1:0]   weights,
    input  logic [1:0]       avg_sel,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    output logic             sat,
    output logic             busy
);

    localparam int DW = $clog2(M);
    localparam int AW = N + DW;
    localparam int SW = N + AVG_MAX_LOG2;
    localparam int CW = AVG_MAX_LOG2 + 1;

    localparam logic [DW-1:0] LAST_DEC = DW'(M - 1);
    localparam logic [AW-1:0] CODE_MAX = {{(AW-N){1'b0}}, {N{1'b1}}};
    localparam logic [1:0]    AVG_MAX  = 2'(AVG_MAX_LOG2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ACC  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dec_cnt_q, dec_cnt_d;
    logic [CW-1:0]   conv_cnt_q, conv_cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [1:0]      avg_q, avg_d;
    logic            grp_sat_q, grp_sat_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    logic            sat_q, sat_d;

    logic [N-1:0]    w_sel;
    logic            clamp;
    logic [N-1:0]    code;
    logic [SW-1:0]   sum_inc;
    logic            conv_last;
    logic [1:0]      avg_eff;

    assign w_sel     = weights[dec_cnt_q*N +: N];
    assign clamp     = (acc_q > CODE_MAX);
    assign code      = clamp ? {N{1'b1}} : acc_q[N-1:0];
    assign sum_inc   = sum_q + SW'(code);
    assign conv_last = (conv_cnt_q == ((CW'(1) << avg_q) - CW'(1)));
    assign avg_eff   = (avg_sel > AVG_MAX) ? AVG_MAX : avg_sel;

    always_comb begin
        state_d      = state_q;
        dec_cnt_d    = dec_cnt_q;
        conv_cnt_d   = conv_cnt_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        avg_d        = avg_q;
        grp_sat_d    = grp_sat_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sat_d        = sat_q;

        // Abort wins over everything; the next start re-initialises the group state.
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = CONV;
                        avg_d      = avg_eff;
                        dec_cnt_d  = '0;
                        conv_cnt_d = '0;
                        acc_d      = '0;
                        sum_d      = '0;
                        grp_sat_d  = 1'b0;
                    end
                end
                CONV: begin
                    if (cmp_valid) begin
                        if (cmp) begin
                            acc_d = acc_q + AW'(w_sel);
                        end
                        dec_cnt_d = dec_cnt_q + DW'(1);
                        if (dec_cnt_q == LAST_DEC) begin
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    sum_d      = sum_inc;
                    conv_cnt_d = conv_cnt_q + CW'(1);
                    grp_sat_d  = grp_sat_q | clamp;
                    if (conv_last) begin
                        dout_d       = N'(sum_inc >> avg_q);
                        sat_d        = grp_sat_q | clamp;
                        dout_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        acc_d     = '0;
                        dec_cnt_d = '0;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (start) begin
                        state_d = CONV;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            dec_cnt_q    <= '0;
            conv_cnt_q   <= '0;
            acc_q        <= '0;
            sum_q        <= '0;
            avg_q        <= '0;
            grp_sat_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            conv_cnt_q   <= conv_cnt_d;
            acc_q        <= acc_d;
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            grp_sat_q    <= grp_sat_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sat_q        <= sat_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sat        = sat_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_sar_redundant_recon.sv
// Bench for adc_sar_redundant_recon: vector table, hand-written corner sequences and random groups
// checked against an arithmetic model of code reconstruction and averaging.
module tb_adc_sar_redundant_recon;

    localparam int N = 8;
    localparam int M = 10;
    localparam int A = 3;

    localparam logic [M*N-1:0] W_BIN = {8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128};
    localparam logic [M*N-1:0] W_RED = {8'd1, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd32, 8'd64, 8'd128};

    logic           clk = 1'b0;
    logic           rstb = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           cmp_valid = 1'b0;
    logic           cmp = 1'b0;
    logic [M*N-1:0] weights = W_BIN;
    logic [1:0]     avg_sel = 2'd0;
    logic [N-1:0]   dout;
    logic           dout_valid;
    logic           sat;
    logic           busy;

    adc_sar_redundant_recon #(.N(N), .M(M), .AVG_MAX_LOG2(A)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .abort      (abort),
        .cmp_valid  (cmp_valid),
        .cmp        (cmp),
        .weights    (weights),
        .avg_sel    (avg_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sat        (sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_dout = 0;
    int last_sat = 0;
    logic [M-1:0] pat_q[$];

    typedef struct {
        string          name;
        logic [M*N-1:0] w;
        logic [M-1:0]   bits;
        int             exp_dout;
        int             exp_sat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: weighted sum of the decisions with the current weight table.
    function automatic int raw_sum(input logic [M-1:0] b, input logic [M*N-1:0] w);
        int s = 0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) s += int'(w[i*N +: N]);
        end
        return s;
    endfunction

    // One conversion: start pulse, M decisions, returns in the ACC cycle.
    task automatic conv(input logic [M-1:0] b, input bit noisy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (noisy && $urandom_range(0, 2) == 0) begin
                cmp_valid = 1'b0;
                cmp = 1'($urandom_range(0, 1));
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            cmp_valid = 1'b1;
            cmp = b[i];
            if (noisy && i == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cmp_valid = noisy;
        cmp = 1'b1;
    endtask

    task automatic run_group(input int avg, input bit noisy, input string tag);
        int eff;
        int n;
        int sum;
        int anysat;
        int raw;
        int exp;
        eff = (avg > A) ? A : avg;
        n = 1 << eff;
        sum = 0;
        anysat = 0;
        avg_sel = 2'(avg);
        for (int k = 0; k < n; k++) begin
            raw = raw_sum(pat_q[k], weights);
            sum += (raw > 255) ? 255 : raw;
            if (raw > 255) anysat = 1;
            conv(pat_q[k], noisy);
            avg_sel = 2'($urandom_range(0, 3));
            chk({tag, " valid_in_acc"}, int'(dout_valid), 0);
            chk({tag, " busy_in_acc"}, int'(busy), 1);
            @(negedge clk);
            cmp_valid = 1'b0;
            if (k < n - 1) begin
                chk({tag, " valid_in_wait"}, int'(dout_valid), 0);
                chk({tag, " busy_in_wait"}, int'(busy), 1);
                if (noisy) begin
                    cmp_valid = 1'b1;
                    @(negedge clk);
                    @(negedge clk);
                    cmp_valid = 1'b0;
                end
            end else begin
                exp = sum >> eff;
                chk({tag, " valid"}, int'(dout_valid), 1);
                chk({tag, " dout"}, int'(dout), exp);
                chk({tag, " sat"}, int'(sat), anysat);
                last_dout = exp;
                last_sat = anysat;
                @(negedge clk);
                chk({tag, " valid_one_cycle"}, int'(dout_valid), 0);
                chk({tag, " busy_idle"}, int'(busy), 0);
                chk({tag, " dout_hold"}, int'(dout), last_dout);
            end
        end
        pat_q.delete();
    endtask

    initial begin
        int hits;
        logic [M*N-1:0] wr;

        vecs[0] = '{"bin171",  W_BIN, 10'b0011010101, 171, 0};
        vecs[1] = '{"red_all1", W_RED, 10'b1111111111, 255, 1};
        vecs[2] = '{"red_all0", W_RED, 10'b0000000000, 0,   0};
        vecs[3] = '{"bin_max",  W_BIN, 10'b1111111111, 255, 0};
        vecs[4] = '{"red192",   W_RED, 10'b0000001101, 192, 0};
        vecs[5] = '{"red256",   W_RED, 10'b0000001111, 255, 1};
        vecs[6] = '{"red160",   W_RED, 10'b1111111110, 160, 0};

        #1;
        chk("reset dout", int'(dout), 0);
        chk("reset valid", int'(dout_valid), 0);
        chk("reset sat", int'(sat), 0);
        chk("reset busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            weights = vecs[v].w;
            pat_q.push_back(vecs[v].bits);
            run_group(0, 1'b0, vecs[v].name);
            chk({vecs[v].name, " table_dout"}, int'(dout), vecs[v].exp_dout);
            chk({vecs[v].name, " table_sat"}, int'(sat), vecs[v].exp_sat);
        end

        // Ignored start/cmp_valid and decision gaps must not change the result.
        weights = W_BIN;
        pat_q.push_back(10'b0011010101);
        run_group(0, 1'b1, "noisy171");
        chk("noisy171 table_dout", int'(dout), 171);

        // Four-way average of 100..103.
        pat_q.push_back(10'b0000100110);
        pat_q.push_back(10'b0010100110);
        pat_q.push_back(10'b0001100110);
        pat_q.push_back(10'b0011100110);
        run_group(2, 1'b0, "avg4");
        chk("avg4 table_dout", int'(dout), 101);

        // Abort after five decisions, with start and cmp_valid asserted alongside.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmp_valid = 1'b1;
            cmp = 1'b1;
            @(negedge clk);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        cmp_valid = 1'b0;
        chk("abort busy", int'(busy), 0);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            if (dout_valid) hits++;
            @(negedge clk);
        end
        chk("abort no_valid", hits, 0);
        chk("abort dout_hold", int'(dout), last_dout);
        chk("abort sat_hold", int'(sat), last_sat);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort idle", int'(busy), 0);
        pat_q.push_back(10'b0011010101);
        run_group(0, 1'b0, "post_abort");

        // Reset during the third conversion of a four-way group.
        avg_sel = 2'd2;
        for (int k = 0; k < 2; k++) begin
            conv(M'($urandom), 1'b0);
            cmp_valid = 1'b0;
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp_valid = 1'b1;
            cmp = 1'b1;
            @(negedge clk);
        end
        cmp_valid = 1'b0;
        rstb = 1'b0;
        #1;
        chk("midreset dout", int'(dout), 0);
        chk("midreset valid", int'(dout_valid), 0);
        chk("midreset sat", int'(sat), 0);
        chk("midreset busy", int'(busy), 0);
        @(negedge clk);
        rstb = 1'b1;
        last_dout = 0;
        last_sat = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) pat_q.push_back(M'($urandom));
        run_group(2, 1'b0, "post_reset");

        // Random groups.
        for (int g = 0; g < 25; g++) begin
            int avg;
            avg = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: weights = W_BIN;
                1: weights = W_RED;
                default: begin
                    for (int i = 0; i < M; i++) wr[i*N +: N] = N'($urandom_range(0, 60));
                    weights = wr;
                end
            endcase
            for (int k = 0; k < (1 << avg); k++) pat_q.push_back(M'($urandom));
            run_group(avg, 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sar_redundant_recon.md
ADC_SAR_REDUNDANT_RECON -- requirements
Module: adc_sar_redundant_recon

Interface
REQ-001 SHALL have parameter N, default 8: output code width in bits.
REQ-002 SHALL have parameter M, default 10: comparator decisions per conversion; M >= N.
REQ-003 SHALL have parameter AVG_MAX_LOG2, default 3: maximum averaging exponent; 0..3.
REQ-004 SHALL have port clk  input  1: clock; all logic on rising edge.
REQ-005 SHALL have port rstb  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1: one-cycle pulse that begins a conversion.
REQ-007 SHALL have port abort  input  1: synchronous cancel of the current group.
REQ-008 SHALL have port cmp_valid  input  1: comparator decision strobe.
REQ-009 SHALL have port cmp  input  1: comparator decision; 1 = add weight.
REQ-010 SHALL have port weights  input  M*N: weight table; bits [i*N +: N] = weight of decision i, decision 0 first; static while busy.
REQ-011 SHALL have port avg_sel  input  2: number of conversions averaged = 2**avg_sel, values above AVG_MAX_LOG2 saturated to AVG_MAX_LOG2.
REQ-012 SHALL have port dout  output  N: averaged code.
REQ-013 SHALL have port dout_valid  output  1: one-cycle strobe, dout updated.
REQ-014 SHALL have port sat  output  1: at least one conversion of the group clamped.
REQ-015 SHALL have port busy  output  1: group in progress.

Function
REQ-016 SHALL implement FSM states IDLE, CONV, ACC, WAIT.
REQ-017 IDLE: start -> CONV, latch avg_sel, clear decision counter, conversion counter, accumulator, group sum, sat flag.
REQ-018 CONV: each cycle with cmp_valid=1, accumulator += cmp ? weight[i] : 0, i = decision counter, counter += 1; cmp_valid=0 leaves all unchanged.
REQ-019 CONV -> ACC on the edge sampling the M-th cmp_valid.
REQ-020 Accumulator width SHALL be N+clog2(M) bits, unsigned, never wrapping.
REQ-021 ACC (one cycle): conversion code = min(accumulator, 2**N-1); clamp sets group sat flag; group sum (N+AVG_MAX_LOG2 bits) += code; conversion counter += 1.
REQ-022 ACC, last conversion of group: dout <= group sum incl. current code >> latched avg_sel (truncation), sat <= group flag, dout_valid <= 1, state -> IDLE.
REQ-023 ACC, otherwise: state -> WAIT; accumulator and decision counter cleared.
REQ-024 WAIT: start -> CONV; group sum, counters and latched avg_sel kept.
REQ-025 Latency: dout_valid SHALL be high in the 2nd cycle after the edge sampling the M-th cmp_valid of the last conversion.
REQ-026 dout_valid SHALL be high for exactly one cycle; dout and sat SHALL hold until next dout_valid.
REQ-027 busy SHALL be 1 in CONV, ACC, WAIT and 0 in IDLE.
REQ-028 start while in CONV or ACC SHALL be ignored.
REQ-029 cmp_valid in IDLE, WAIT or ACC SHALL be ignored.
REQ-030 abort in any state SHALL go to IDLE on the next edge, discard group, no dout_valid, dout/sat unchanged; abort has priority over start and cmp_valid.
REQ-031 start and abort in same cycle in IDLE: stay IDLE.
REQ-032 Weight 0 entries SHALL be legal (shorter effective conversion).

Reset
REQ-033 rstb=0 SHALL asynchronously force IDLE, dout=0, dout_valid=0, sat=0, busy=0, all counters, accumulator, group sum = 0.
REQ-034 Reset mid-operation SHALL discard the group; first start after release behaves as from power-up.

Verification
REQ-035 N=8, M=10, weights {128,64,32,16,8,4,2,1,0,0}, avg_sel=0, cmp 1,0,1,0,1,0,1,1,0,0 -> dout=171, dout_valid one cycle, 2 cycles after 10th cmp_valid edge, sat=0.
REQ-036 weights {128,64,32,32,16,8,4,2,1,1}, all cmp=1 -> sum 288 -> dout=255, sat=1; next conversion all cmp=0 -> dout=0, sat=0.
REQ-037 avg_sel=2, four conversions coding 100,101,102,103 -> single dout_valid after 4th, dout=101; busy high from first start through 4th ACC, including WAIT gaps.
REQ-038 start pulsed during CONV and cmp_valid during WAIT -> no effect, result identical to REQ-035; cmp_valid gaps in CONV -> same result.
REQ-039 abort after 5th decision -> busy=0 next cycle, no dout_valid, dout keeps prior value; next clean conversion correct.
REQ-040 rstb low during CONV of 3rd of 4 averaged conversions -> all outputs 0 immediately; new group after release gives correct average with no residue.
